opcode_decoder_tx: RTL and testbench

Transmit-side decoder that turns the 4-bit Brainfuck opcode stream back into printable ASCII symbols for the console/UART path. It accepts opcodes over a valid/ready handshake and produces one registered ASCII byte per accepted opcode over a second valid/ready handshake. It inserts CR/LF line breaks after a fixed column count or on a flush request. It sits between program memory readback (dump/listing) and the serial transmitter.

---
 rtl/opcode_decoder_tx.sv | 148 ++++++++++++++
 tb/tb_opcode_decoder_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_decoder_tx.sv
// Transmit-side opcode decoder: turns 4-bit Brainfuck opcodes into ASCII
// symbols over a registered valid/ready output. Inserts CR/LF after LINE_LEN
// symbols or on a flush request.
module opcode_decoder_tx #(
    parameter int unsigned LINE_LEN = 64,
    parameter bit          SKIP_NOP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] opcode,
    input  logic       flush,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [7:0] symbol,
    output logic       bad_op,
    output logic       busy
);

    localparam int unsigned ColW = (LINE_LEN == 0) ? 1 : $clog2(LINE_LEN + 1);
    localparam logic [ColW-1:0] LineLenC = ColW'(LINE_LEN);

    localparam logic [1:0] StEmit   = 2'd0;
    localparam logic [1:0] StCrPend = 2'd1;
    localparam logic [1:0] StLfPend = 2'd2;

    localparam logic [7:0] AsciiCr = 8'h0D;
    localparam logic [7:0] AsciiLf = 8'h0A;

    logic [1:0]      state_q, state_d;
    logic [ColW-1:0] col_q, col_d;
    logic [ColW-1:0] col_inc;
    logic            sym_valid_q, sym_valid_d;
    logic [7:0]      symbol_q, symbol_d;
    logic            bad_op_q, bad_op_d;
    logic            busy_q, busy_d;

    logic            free;
    logic [7:0]      dec_sym;
    logic            dec_emit;
    logic            dec_bad;

    // Output register can take a new byte when empty or being drained this cycle.
    assign free     = !sym_valid_q || sym_ready;
    assign op_ready = (state_q == StEmit) && free && !flush;
    assign col_inc  = col_q + 1'b1;

    // Opcode to ASCII map; invalid opcodes print '?' and flag bad_op.
    always_comb begin
        dec_sym  = 8'h3F;
        dec_emit = 1'b1;
        dec_bad  = 1'b0;
        case (opcode)
            4'd0: begin
                dec_sym  = 8'h20;
                dec_emit = !SKIP_NOP;
            end
            4'd1:    dec_sym = 8'h2B;
            4'd2:    dec_sym = 8'h2D;
            4'd3:    dec_sym = 8'h3E;
            4'd4:    dec_sym = 8'h3C;
            4'd5:    dec_sym = 8'h5B;
            4'd6:    dec_sym = 8'h5D;
            4'd7:    dec_sym = 8'h2E;
            4'd8:    dec_sym = 8'h2C;
            default: dec_bad = 1'b1;
        endcase
    end

    // Next-state: load at most one byte per free cycle; otherwise hold everything.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        sym_valid_d = sym_valid_q;
        symbol_d    = symbol_q;
        bad_op_d    = bad_op_q;

        if (free) begin
            // Old byte is gone (or never there); stays empty unless reloaded below.
            sym_valid_d = 1'b0;
            case (state_q)
                StEmit: begin
                    if (flush) begin
                        // Flush on an empty line is a no-op.
                        if (col_q != '0) begin
                            symbol_d    = AsciiCr;
                            sym_valid_d = 1'b1;
                            col_d       = '0;
                            state_d     = StLfPend;
                        end
                    end else if (op_valid) begin
                        bad_op_d = bad_op_q | dec_bad;
                        if (dec_emit) begin
                            symbol_d    = dec_sym;
                            sym_valid_d = 1'b1;
                            col_d       = col_inc;
                            if ((LINE_LEN != 0) && (col_inc == LineLenC)) begin
                                state_d = StCrPend;
                            end
                        end
                    end
                end
                StCrPend: begin
                    symbol_d    = AsciiCr;
                    sym_valid_d = 1'b1;
                    col_d       = '0;
                    state_d     = StLfPend;
                end
                StLfPend: begin
                    symbol_d    = AsciiLf;
                    sym_valid_d = 1'b1;
                    state_d     = StEmit;
                end
                default: begin
                    state_d = StEmit;
                end
            endcase
        end

        busy_d = sym_valid_d || (state_d != StEmit);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmit;
            col_q       <= '0;
            sym_valid_q <= 1'b0;
            symbol_q    <= 8'h00;
            bad_op_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            sym_valid_q <= sym_valid_d;
            symbol_q    <= symbol_d;
            bad_op_q    <= bad_op_d;
            busy_q      <= busy_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign symbol    = symbol_q;
    assign bad_op    = bad_op_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_opcode_decoder_tx.sv
// Bench for opcode_decoder_tx: cycle-accurate vector table on a LINE_LEN=4
// instance, async-reset and random-backpressure sequences, and a short
// SKIP_NOP=0 / no-wrap sequence on a second instance.
module tb_opcode_decoder_tx;

    typedef struct {
        logic       ov;
        logic [3:0] op;
        logic       fl;
        logic       sr;
        logic       e_rdy;
        logic       e_sv;
        logic [7:0] e_sym;
        logic       e_bad;
        logic       e_busy;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] opcode;
    logic       flush;
    logic       sym_valid;
    logic       sym_ready;
    logic [7:0] symbol;
    logic       bad_op;
    logic       busy;

    logic       n_op_valid;
    logic       n_op_ready;
    logic [3:0] n_opcode;
    logic       n_flush;
    logic       n_sym_valid;
    logic       n_sym_ready;
    logic [7:0] n_symbol;
    logic       n_bad_op;
    logic       n_busy;

    int checks = 0;
    int errors = 0;

    opcode_decoder_tx #(
        .LINE_LEN(4),
        .SKIP_NOP(1'b1)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .opcode   (opcode),
        .flush    (flush),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .symbol   (symbol),
        .bad_op   (bad_op),
        .busy     (busy)
    );

    opcode_decoder_tx #(
        .LINE_LEN(0),
        .SKIP_NOP(1'b0)
    ) u_dut_nop (
        .clk      (clk),
        .rst      (rst),
        .op_valid (n_op_valid),
        .op_ready (n_op_ready),
        .opcode   (n_opcode),
        .flush    (n_flush),
        .sym_valid(n_sym_valid),
        .sym_ready(n_sym_ready),
        .symbol   (n_symbol),
        .bad_op   (n_bad_op),
        .busy     (n_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ov, input logic [3:0] op, input logic fl,
                                input logic sr, input logic er, input logic esv,
                                input logic [7:0] es, input logic eb, input logic ebz);
        vec_t v;
        v.ov = ov; v.op = op; v.fl = fl; v.sr = sr;
        v.e_rdy = er; v.e_sv = esv; v.e_sym = es; v.e_bad = eb; v.e_busy = ebz;
        return v;
    endfunction

    // Entered at posedge+1: drive, check op_ready mid-cycle, check registers after edge.
    task automatic apply(input vec_t v, input string tag, input int idx);
        op_valid  = v.ov;
        opcode    = v.op;
        flush     = v.fl;
        sym_ready = v.sr;
        @(negedge clk);
        chk($sformatf("%s[%0d].op_ready", tag, idx), op_ready, v.e_rdy);
        @(posedge clk);
        #1;
        chk($sformatf("%s[%0d].sym_valid", tag, idx), sym_valid, v.e_sv);
        if (v.e_sv) chk($sformatf("%s[%0d].symbol", tag, idx), symbol, v.e_sym);
        chk($sformatf("%s[%0d].bad_op", tag, idx), bad_op, v.e_bad);
        chk($sformatf("%s[%0d].busy", tag, idx), busy, v.e_busy);
    endtask

    function automatic logic [7:0] ref_map(input logic [3:0] op);
        logic [7:0] tbl [16];
        tbl = '{8'h00, 8'h2B, 8'h2D, 8'h3E, 8'h3C, 8'h5B, 8'h5D, 8'h2E,
                8'h2C, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
        return tbl[op];
    endfunction

    initial begin
        vec_t       vecs[$];
        vec_t       post[$];
        logic [3:0] rops[200];
        logic [7:0] expq[$];
        logic [3:0] nops[6];
        logic [7:0] nexp[6];
        int         col;
        int         idx;
        int         cyc;
        logic       acc;
        logic       held;
        logic [7:0] hsym;

        clk = 1'b0; rst = 1'b1;
        op_valid = 1'b0; opcode = 4'd0; flush = 1'b0; sym_ready = 1'b1;
        n_op_valid = 1'b0; n_opcode = 4'd0; n_flush = 1'b0; n_sym_ready = 1'b1;

        // Main table: map sweep with auto-wrap, invalid/NOP, flush, backpressure,
        // flush ignored while a wrap is pending.
        vecs.push_back(mk(1, 4'd1, 0, 1, 1, 1, 8'h2B, 0, 1));
        vecs.push_back(mk(1, 4'd2, 0, 1, 1, 1, 8'h2D, 0, 1));
        vecs.push_back(mk(1, 4'd3, 0, 1, 1, 1, 8'h3E, 0, 1));
        vecs.push_back(mk(1, 4'd4, 0, 1, 1, 1, 8'h3C, 0, 1));
        vecs.push_back(mk(1, 4'd5, 0, 1, 0, 1, 8'h0D, 0, 1));
        vecs.push_back(mk(1, 4'd5, 0, 1, 0, 1, 8'h0A, 0, 1));
        vecs.push_back(mk(1, 4'd5, 0, 1, 1, 1, 8'h5B, 0, 1));
        vecs.push_back(mk(1, 4'd6, 0, 1, 1, 1, 8'h5D, 0, 1));
        vecs.push_back(mk(1, 4'd7, 0, 1, 1, 1, 8'h2E, 0, 1));
        vecs.push_back(mk(1, 4'd8, 0, 1, 1, 1, 8'h2C, 0, 1));
        vecs.push_back(mk(0, 4'd0, 0, 1, 0, 1, 8'h0D, 0, 1));
        vecs.push_back(mk(0, 4'd0, 0, 1, 0, 1, 8'h0A, 0, 1));
        vecs.push_back(mk(0, 4'd0, 0, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 4'd9, 0, 1, 1, 1, 8'h3F, 1, 1));
        vecs.push_back(mk(1, 4'd0, 0, 1, 1, 0, 8'h00, 1, 0));
        vecs.push_back(mk(1, 4'd15, 0, 1, 1, 1, 8'h3F, 1, 1));
        vecs.push_back(mk(0, 4'd0, 0, 1, 1, 0, 8'h00, 1, 0));
        vecs.push_back(mk(1, 4'd1, 0, 1, 1, 1, 8'h2B, 1, 1));
        vecs.push_back(mk(1, 4'd1, 1, 1, 0, 1, 8'h0D, 1, 1));
        vecs.push_back(mk(1, 4'd1, 1, 1, 0, 1, 8'h0A, 1, 1));
        vecs.push_back(mk(1, 4'd1, 1, 1, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(1, 4'd1, 0, 1, 1, 1, 8'h2B, 1, 1));
        vecs.push_back(mk(1, 4'd2, 0, 0, 0, 1, 8'h2B, 1, 1));
        vecs.push_back(mk(1, 4'd2, 0, 0, 0, 1, 8'h2B, 1, 1));
        vecs.push_back(mk(1, 4'd2, 0, 1, 1, 1, 8'h2D, 1, 1));
        vecs.push_back(mk(0, 4'd0, 0, 1, 1, 0, 8'h00, 1, 0));
        vecs.push_back(mk(1, 4'd3, 0, 1, 1, 1, 8'h3E, 1, 1));
        vecs.push_back(mk(1, 4'd3, 0, 1, 1, 1, 8'h3E, 1, 1));
        vecs.push_back(mk(0, 4'd0, 1, 0, 0, 1, 8'h3E, 1, 1));
        vecs.push_back(mk(0, 4'd0, 1, 1, 0, 1, 8'h0D, 1, 1));
        vecs.push_back(mk(0, 4'd0, 1, 1, 0, 1, 8'h0A, 1, 1));
        vecs.push_back(mk(0, 4'd0, 1, 1, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(0, 4'd0, 0, 1, 1, 0, 8'h00, 1, 0));

        // After async reset: col must restart, so the 4th symbol wraps.
        post.push_back(mk(1, 4'd3, 0, 1, 1, 1, 8'h3E, 0, 1));
        post.push_back(mk(1, 4'd1, 0, 1, 1, 1, 8'h2B, 0, 1));
        post.push_back(mk(1, 4'd1, 0, 1, 1, 1, 8'h2B, 0, 1));
        post.push_back(mk(1, 4'd1, 0, 1, 1, 1, 8'h2B, 0, 1));
        post.push_back(mk(0, 4'd0, 0, 1, 0, 1, 8'h0D, 0, 1));

        #2;
        chk("reset.sym_valid", sym_valid, 1'b0);
        chk("reset.symbol", symbol, 8'h00);
        chk("reset.bad_op", bad_op, 1'b0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.op_ready", op_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "vec", i);

        // Fill a line so CR is pending with a held symbol, then reset between edges.
        for (int i = 0; i < 4; i++) apply(mk(1, 4'd1, 0, 1, 1, 1, 8'h2B, 1, 1), "prerst", i);
        op_valid  = 1'b0;
        sym_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.sym_valid", sym_valid, 1'b0);
        chk("async_rst.symbol", symbol, 8'h00);
        chk("async_rst.bad_op", bad_op, 1'b0);
        chk("async_rst.busy", busy, 1'b0);
        chk("async_rst.op_ready", op_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < post.size(); i++) apply(post[i], "postrst", i);

        // Random backpressure against a stream model.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        col = 0;
        for (int i = 0; i < 200; i++) begin
            rops[i] = 4'($urandom_range(0, 15));
            if (rops[i] != 4'd0) begin
                expq.push_back(ref_map(rops[i]));
                col++;
                if (col == 4) begin
                    expq.push_back(8'h0D);
                    expq.push_back(8'h0A);
                    col = 0;
                end
            end
        end
        idx  = 0;
        cyc  = 0;
        held = 1'b0;
        hsym = 8'h00;
        while ((idx < 200 || expq.size() > 0) && cyc < 5000) begin
            op_valid  = (idx < 200);
            opcode    = (idx < 200) ? rops[idx] : 4'd0;
            flush     = 1'b0;
            sym_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = op_valid && op_ready;
            if (sym_valid && sym_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand.extra: got %0h expected no byte", symbol);
                end else begin
                    chk("rand.symbol", symbol, expq.pop_front());
                end
            end
            held = sym_valid && !sym_ready;
            hsym = symbol;
            @(posedge clk);
            #1;
            if (held) begin
                chk("rand.hold_valid", sym_valid, 1'b1);
                chk("rand.hold_symbol", symbol, hsym);
            end
            if (acc) idx++;
            cyc++;
        end
        chk("rand.ops_accepted", idx, 200);
        chk("rand.bytes_left", expq.size(), 0);
        op_valid  = 1'b0;
        sym_ready = 1'b1;

        // SKIP_NOP=0, LINE_LEN=0: NOP prints a space and no wrap ever happens.
        nops = '{4'd9, 4'd0, 4'd15, 4'd1, 4'd1, 4'd1};
        nexp = '{8'h3F, 8'h20, 8'h3F, 8'h2B, 8'h2B, 8'h2B};
        for (int i = 0; i < 6; i++) begin
            n_op_valid = 1'b1;
            n_opcode   = nops[i];
            @(negedge clk);
            chk($sformatf("nop[%0d].op_ready", i), n_op_ready, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("nop[%0d].sym_valid", i), n_sym_valid, 1'b1);
            chk($sformatf("nop[%0d].symbol", i), n_symbol, nexp[i]);
        end
        n_op_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("nop.idle_valid", n_sym_valid, 1'b0);
        chk("nop.bad_op", n_bad_op, 1'b1);
        chk("nop.busy", n_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
